// File: rtl/comb_pair_sequencer.sv
// Two-channel sample pairing sequencer: per-channel FIFOs, lockstep pop, packed 48-bit output stream.
// Optional statistics outputs (pair_count, skew_err) are enabled by defining COMB_SEQ_STATS_EN.
//
// state   | meaning
// S_IDLE  | inputs accepted and discarded, FIFOs empty, waiting for enable
// S_RUN   | inputs buffered per channel, pairs packed into the output register
// S_FLUSH | inputs discarded, waiting for the pending output beat to drain
module comb_pair_sequencer #(
   parameter int IN_DATA_WIDTH  = 24,
   parameter int OUT_DATA_WIDTH = 48,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic                      fract,
   input  logic [IN_DATA_WIDTH-1:0]  a_tdata,
   input  logic                      a_tvalid,
   output logic                      a_tready,
   input  logic [IN_DATA_WIDTH-1:0]  b_tdata,
   input  logic                      b_tvalid,
   output logic                      b_tready,
   output logic [OUT_DATA_WIDTH-1:0] m_tdata,
   output logic                      m_tvalid,
   input  logic                      m_tready,
   output logic                      busy
`ifdef COMB_SEQ_STATS_EN
   ,
   output logic [31:0]               pair_count,
   output logic                      skew_err
`endif
);

   localparam int IW = IN_DATA_WIDTH;
   localparam int H  = OUT_DATA_WIDTH / 2;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

   state_t state_q, state_d;

   logic [IW-1:0] mem_q [2][FIFO_DEPTH];
   logic [AW-1:0] wptr_q [2];
   logic [AW-1:0] rptr_q [2];
   logic [CW-1:0] cnt_q  [2];

   logic [IW-1:0] din [2];
   logic [1:0]    tvalid;
   logic [1:0]    tready;
   logic [1:0]    wr;
   logic [1:0]    full;
   logic [1:0]    empty;
   logic          run;
   logic          load;
   logic          out_acc;
   logic          fifo_clr;
   logic          run_start;

   logic                      m_tvalid_q;
   logic [OUT_DATA_WIDTH-1:0] m_tdata_q;

   // fract=1 halves the sample (arithmetic shift) before sign-extending into the lane
   function automatic logic [H-1:0] pack_lane(input logic [IW-1:0] s, input logic fr);
      logic [IW-1:0] v;
      v = fr ? {s[IW-1], s[IW-1:1]} : s;
      return H'($signed(v));
   endfunction

   assign din[0] = a_tdata;
   assign din[1] = b_tdata;
   assign tvalid = {b_tvalid, a_tvalid};

   always_comb begin
      for (int c = 0; c < 2; c++) begin
         full[c]  = (cnt_q[c] == CW'(FIFO_DEPTH));
         empty[c] = (cnt_q[c] == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (enable) state_d = S_RUN;
         S_RUN:   if (!enable) state_d = S_FLUSH;
         S_FLUSH: if (!m_tvalid_q || m_tready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      run       = (state_q == S_RUN);
      busy      = (state_q != S_IDLE);
      run_start = (state_q == S_IDLE) && enable;
      fifo_clr  = (state_q == S_FLUSH) && (state_d == S_IDLE);
      for (int c = 0; c < 2; c++) begin
         tready[c] = run ? !full[c] : 1'b1;
         wr[c]     = run && tvalid[c] && !full[c];
      end
      load    = run && !empty[0] && !empty[1] && (!m_tvalid_q || m_tready);
      out_acc = m_tvalid_q && m_tready;
   end

   assign a_tready = tready[0];
   assign b_tready = tready[1];

   always_ff @(posedge clk) begin
      if (rst || fifo_clr) begin
         for (int c = 0; c < 2; c++) begin
            wptr_q[c] <= '0;
            rptr_q[c] <= '0;
            cnt_q[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (wr[c]) begin
               mem_q[c][wptr_q[c]] <= din[c];
               wptr_q[c]           <= wptr_q[c] + AW'(1);
            end
            if (load) begin
               rptr_q[c] <= rptr_q[c] + AW'(1);
            end
            cnt_q[c] <= cnt_q[c] + CW'(wr[c]) - CW'(load);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_tvalid_q <= 1'b0;
         m_tdata_q  <= '0;
      end else if (load) begin
         m_tvalid_q <= 1'b1;
         m_tdata_q  <= {pack_lane(mem_q[1][rptr_q[1]], fract),
                        pack_lane(mem_q[0][rptr_q[0]], fract)};
      end else if (out_acc) begin
         m_tvalid_q <= 1'b0;
      end
   end

   assign m_tvalid = m_tvalid_q;
   assign m_tdata  = m_tdata_q;

`ifdef COMB_SEQ_STATS_EN
   logic [31:0] pair_count_q;
   logic        skew_err_q;

   always_ff @(posedge clk) begin
      if (rst || run_start) begin
         pair_count_q <= '0;
         skew_err_q   <= 1'b0;
      end else begin
         if (out_acc) begin
            pair_count_q <= pair_count_q + 32'd1;
         end
         if (run && ((full[0] && empty[1]) || (full[1] && empty[0]))) begin
            skew_err_q <= 1'b1;
         end
      end
   end

   assign pair_count = pair_count_q;
   assign skew_err   = skew_err_q;
`else
   logic unused_run_start;
   assign unused_run_start = run_start;
`endif

endmodule
